fp_addsub_pipe: RTL and testbench



---
 rtl/fp_addsub_pipe.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: three-stage pipelined floating-point adder/subtractor.
// Subnormal inputs and results flush to zero. Rounding is round-to-nearest-even.
// Every NaN result is the canonical quiet NaN.
// Ports:
//   clock, nreset                      clock and asynchronous active-low reset
//   in_valid, in_ready                 operand handshake
//   a, b, op_sub                       operands; op_sub=1 computes a-b
//   out_valid, out_ready               result handshake
//   result                             rounded result
//   flags                              {invalid, overflow, underflow, inexact}
module fp_addsub_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 7
) (
    input  logic                 clock,
    input  logic                 nreset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 op_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);
    localparam int unsigned W   = 1 + EXP_W + MAN_W;
    localparam int unsigned FW  = MAN_W + 4;             // hidden, mantissa, G, R, S
    localparam int unsigned MW1 = MAN_W + 1;
    localparam int unsigned LZW = $clog2(FW + 1);
    localparam int unsigned XW  = ((EXP_W > LZW) ? EXP_W : LZW) + 2;

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    // ---------------------------------------------------------------- handshake
    logic s1_valid, s2_valid;
    logic s1_free, s2_free, s3_free;

    // A stage may load when it is empty or its content moves on this edge
    assign s3_free  = !out_valid || out_ready;
    assign s2_free  = !s2_valid || s3_free;
    assign s1_free  = !s1_valid || s2_free;
    assign in_ready = s1_free;

    // ---------------------------------------------------------------- stage 1: unpack, classify, align
    logic                 sa, sb;
    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     ma, mb;
    logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign sa = a[W-1];
    assign sb = b[W-1] ^ op_sub;
    assign ea = a[W-2:MAN_W];
    assign eb = b[W-2:MAN_W];
    assign ma = a[MAN_W-1:0];
    assign mb = b[MAN_W-1:0];

    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EXP_ONES) && (ma == '0);
    assign b_inf  = (eb == EXP_ONES) && (mb == '0);
    assign a_nan  = (ea == EXP_ONES) && (ma != '0);
    assign b_nan  = (eb == EXP_ONES) && (mb != '0);

    logic             c1_special;
    logic [W-1:0]     c1_spec_res;
    logic [3:0]       c1_spec_flags;

    // Operand combinations whose result is known without arithmetic
    always_comb begin : special_p
        c1_special    = 1'b1;
        c1_spec_res   = '0;
        c1_spec_flags = '0;
        if (a_nan || b_nan) begin
            c1_spec_res = QNAN;
        end else if (a_inf && b_inf && (sa != sb)) begin
            c1_spec_res   = QNAN;
            c1_spec_flags = 4'b1000;
        end else if (a_inf) begin
            c1_spec_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            c1_spec_res = {sb, EXP_ONES, {MAN_W{1'b0}}};
        end else if (a_zero && b_zero) begin
            c1_spec_res = {sa & sb, {(W-1){1'b0}}};
        end else if (a_zero) begin
            c1_spec_res = {sb, eb, mb};
        end else if (b_zero) begin
            c1_spec_res = {sa, ea, ma};
        end else begin
            c1_special = 1'b0;
        end
    end

    logic                 a_ge, x_sign;
    logic [EXP_W-1:0]     x_exp, y_exp, e_diff;
    logic [MAN_W-1:0]     x_man, y_man;
    logic [XW-1:0]        shamt;
    logic [FW-1:0]        y_full, c1_xm, c1_ym;
    logic [2*FW-1:0]      y_wide;

    // X is the larger magnitude so the later subtraction never goes negative
    assign a_ge   = {ea, ma} >= {eb, mb};
    assign x_sign = a_ge ? sa : sb;
    assign x_exp  = a_ge ? ea : eb;
    assign x_man  = a_ge ? ma : mb;
    assign y_exp  = a_ge ? eb : ea;
    assign y_man  = a_ge ? mb : ma;
    assign e_diff = x_exp - y_exp;

    // Saturating the shift at FW leaves only the sticky bit
    assign shamt  = (XW'(e_diff) >= XW'(FW)) ? XW'(FW) : XW'(e_diff);
    assign y_full = {1'b1, y_man, 3'b000};
    assign y_wide = {y_full, {FW{1'b0}}} >> shamt;
    assign c1_ym  = y_wide[2*FW-1:FW] | {{(FW-1){1'b0}}, |y_wide[FW-1:0]};
    assign c1_xm  = {1'b1, x_man, 3'b000};

    logic             s1_special, s1_sign, s1_sub;
    logic [W-1:0]     s1_spec_res;
    logic [3:0]       s1_spec_flags;
    logic [EXP_W-1:0] s1_exp;
    logic [FW-1:0]    s1_xm, s1_ym;

    always_ff @(posedge clock or negedge nreset) begin : s1_reg
        if (!nreset) begin
            s1_valid      <= 1'b0;
            s1_special    <= 1'b0;
            s1_spec_res   <= '0;
            s1_spec_flags <= '0;
            s1_sign       <= 1'b0;
            s1_sub        <= 1'b0;
            s1_exp        <= '0;
            s1_xm         <= '0;
            s1_ym         <= '0;
        end else if (s1_free) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_special    <= c1_special;
                s1_spec_res   <= c1_spec_res;
                s1_spec_flags <= c1_spec_flags;
                s1_sign       <= x_sign;
                s1_sub        <= (sa != sb);
                s1_exp        <= x_exp;
                s1_xm         <= c1_xm;
                s1_ym         <= c1_ym;
            end
        end
    end

    // ---------------------------------------------------------------- stage 2: add, normalise
    logic [FW:0]     sum;
    logic [FW-1:0]   sum_lo;
    logic [LZW-1:0]  lzc;
    logic            lz_found;
    logic [XW-1:0]   e_ext, e_dn;

    assign sum    = s1_sub ? ({1'b0, s1_xm} - {1'b0, s1_ym})
                           : ({1'b0, s1_xm} + {1'b0, s1_ym});
    assign sum_lo = sum[FW-1:0];
    assign e_ext  = XW'(s1_exp);
    assign e_dn   = e_ext - XW'(lzc);

    // Leading-zero count of the carry-free sum
    always_comb begin : lzc_p
        lzc      = '0;
        lz_found = 1'b0;
        for (int i = int'(FW) - 1; i >= 0; i--) begin
            if (!lz_found && sum_lo[i]) begin
                lz_found = 1'b1;
                lzc      = LZW'(int'(FW) - 1 - i);
            end
        end
    end

    logic            c2_sign, c2_zero, c2_uf;
    logic [XW-1:0]   c2_exp;
    logic [FW-1:0]   c2_m;

    always_comb begin : norm_p
        c2_m    = '0;
        c2_exp  = '0;
        c2_zero = 1'b0;
        c2_uf   = 1'b0;
        c2_sign = s1_sign;
        if (sum[FW]) begin
            c2_m   = {sum[FW:2], sum[1] | sum[0]};
            c2_exp = e_ext + XW'(1);
        end else if (sum_lo == '0) begin
            // exact cancellation is always +0
            c2_zero = 1'b1;
            c2_sign = 1'b0;
        end else if (e_dn[XW-1] || (e_dn == '0)) begin
            c2_zero = 1'b1;
            c2_uf   = 1'b1;
        end else begin
            c2_m   = sum_lo << lzc;
            c2_exp = e_dn;
        end
    end

    logic             s2_special, s2_sign, s2_zero, s2_uf;
    logic [W-1:0]     s2_spec_res;
    logic [3:0]       s2_spec_flags;
    logic [XW-1:0]    s2_exp;
    logic [FW-1:0]    s2_m;

    always_ff @(posedge clock or negedge nreset) begin : s2_reg
        if (!nreset) begin
            s2_valid      <= 1'b0;
            s2_special    <= 1'b0;
            s2_spec_res   <= '0;
            s2_spec_flags <= '0;
            s2_sign       <= 1'b0;
            s2_zero       <= 1'b0;
            s2_uf         <= 1'b0;
            s2_exp        <= '0;
            s2_m          <= '0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_special    <= s1_special;
                s2_spec_res   <= s1_spec_res;
                s2_spec_flags <= s1_spec_flags;
                s2_sign       <= c2_sign;
                s2_zero       <= c2_zero;
                s2_uf         <= c2_uf;
                s2_exp        <= c2_exp;
                s2_m          <= c2_m;
            end
        end
    end

    // ---------------------------------------------------------------- stage 3: round, pack
    logic             g_bit, r_bit, s_bit, round_up;
    logic [MAN_W:0]   man_rnd;
    logic [XW-1:0]    e_rnd;
    logic [W-1:0]     c3_res;
    logic [3:0]       c3_flags;

    assign g_bit    = s2_m[2];
    assign r_bit    = s2_m[1];
    assign s_bit    = s2_m[0];
    assign round_up = g_bit && (r_bit || s_bit || s2_m[3]);
    // A carry out of the stored mantissa leaves it all-zero and bumps the exponent
    assign man_rnd  = {1'b0, s2_m[FW-2:3]} + MW1'(round_up);
    assign e_rnd    = s2_exp + XW'(man_rnd[MAN_W]);

    always_comb begin : round_p
        c3_res   = '0;
        c3_flags = '0;
        if (s2_special) begin
            c3_res   = s2_spec_res;
            c3_flags = s2_spec_flags;
        end else if (s2_zero || !s2_m[FW-1]) begin
            c3_res   = {s2_sign, {(W-1){1'b0}}};
            c3_flags = {2'b00, s2_uf, 1'b0};
        end else if (e_rnd >= XW'(EXP_ONES)) begin
            c3_res   = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
            c3_flags = 4'b0101;
        end else begin
            c3_res   = {s2_sign, e_rnd[EXP_W-1:0], man_rnd[MAN_W-1:0]};
            c3_flags = {3'b000, g_bit | r_bit | s_bit};
        end
    end

    always_ff @(posedge clock or negedge nreset) begin : out_reg
        if (!nreset) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (s3_free) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                result <= c3_res;
                flags  <= c3_flags;
            end
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed bf16 vectors, backpressure and reset sequences,
// plus a double-precision sweep compared against real arithmetic.
module tb_fp_addsub_pipe;
    logic        clock, nreset;

    logic        bf_in_valid, bf_in_ready, bf_op, bf_out_valid, bf_out_ready;
    logic [15:0] bf_a, bf_b, bf_result;
    logic [3:0]  bf_flags;

    logic        dp_in_valid, dp_in_ready, dp_op, dp_out_valid, dp_out_ready;
    logic [63:0] dp_a, dp_b, dp_result;
    logic [3:0]  dp_flags;

    fp_addsub_pipe u_bf (
        .clock(clock), .nreset(nreset),
        .in_valid(bf_in_valid), .in_ready(bf_in_ready),
        .a(bf_a), .b(bf_b), .op_sub(bf_op),
        .out_valid(bf_out_valid), .out_ready(bf_out_ready),
        .result(bf_result), .flags(bf_flags)
    );

    fp_addsub_pipe #(.EXP_W(11), .MAN_W(52)) u_dp (
        .clock(clock), .nreset(nreset),
        .in_valid(dp_in_valid), .in_ready(dp_in_ready),
        .a(dp_a), .b(dp_b), .op_sub(dp_op),
        .out_valid(dp_out_valid), .out_ready(dp_out_ready),
        .result(dp_result), .flags(dp_flags)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
        logic [15:0] res;
        logic [3:0]  flg;
    } vec_t;

    localparam int NV = 17;
    vec_t        vecs [NV];
    int          total = 0;
    int          bad   = 0;

    logic [15:0] r16;
    logic [3:0]  f4;
    logic [63:0] r64, ra64, rb64, exp64, tmp64;
    int          lat;
    int          issued, got;
    logic        rdy, vld;
    logic [15:0] rres;
    logic [15:0] bp_a    [4];
    logic [15:0] bp_b    [4];
    logic [15:0] bp_exp  [4];
    real         xr, yr, zr;
    logic        rop;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, expv);
        end
    endtask

    // Issue one bf16 operation, wait for its result; lat counts edges from the accept edge
    task automatic bf_run(input logic [15:0] ta, input logic [15:0] tb, input logic top,
                          output logic [15:0] r, output logic [3:0] f, output int l);
        int n;
        bf_a = ta; bf_b = tb; bf_op = top; bf_in_valid = 1'b1;
        n = 0;
        while (!bf_in_ready && n < 20) begin
            @(posedge clock); #1; n++;
        end
        @(posedge clock); #1;
        bf_in_valid = 1'b0;
        l = 1;
        while (!bf_out_valid && l < 20) begin
            @(posedge clock); #1; l++;
        end
        r = bf_result;
        f = bf_flags;
    endtask

    task automatic dp_run(input logic [63:0] ta, input logic [63:0] tb, input logic top,
                          output logic [63:0] r, output int l);
        int n;
        dp_a = ta; dp_b = tb; dp_op = top; dp_in_valid = 1'b1;
        n = 0;
        while (!dp_in_ready && n < 20) begin
            @(posedge clock); #1; n++;
        end
        @(posedge clock); #1;
        dp_in_valid = 1'b0;
        l = 1;
        while (!dp_out_valid && l < 20) begin
            @(posedge clock); #1; l++;
        end
        r = dp_result;
    endtask

    // Random normal double with exponent near 1.0 so results stay normal
    function automatic logic [63:0] rnd_dbl();
        logic [63:0] v;
        logic [63:0] m;
        m       = {$urandom(), $urandom()};
        v[63]   = 1'($urandom_range(0, 1));
        v[62:52] = 11'(1003 + $urandom_range(0, 40));
        v[51:0] = m[51:0];
        return v;
    endfunction

    initial begin
        vecs[0]  = '{16'h3F80, 16'h3F80, 1'b0, 16'h4000, 4'b0000};
        vecs[1]  = '{16'h3F80, 16'h3F80, 1'b1, 16'h0000, 4'b0000};
        vecs[2]  = '{16'h8000, 16'h0000, 1'b1, 16'h8000, 4'b0000};
        vecs[3]  = '{16'h3F80, 16'h3B80, 1'b0, 16'h3F80, 4'b0001};
        vecs[4]  = '{16'h3F81, 16'h3B80, 1'b0, 16'h3F82, 4'b0001};
        vecs[5]  = '{16'h7F80, 16'hFF80, 1'b0, 16'h7FC0, 4'b1000};
        vecs[6]  = '{16'h7F7F, 16'h7F7F, 1'b0, 16'h7F80, 4'b0101};
        vecs[7]  = '{16'h7FC1, 16'h3F80, 1'b0, 16'h7FC0, 4'b0000};
        vecs[8]  = '{16'h4040, 16'h3F80, 1'b1, 16'h4000, 4'b0000};
        vecs[9]  = '{16'h3F80, 16'h0000, 1'b0, 16'h3F80, 4'b0000};
        vecs[10] = '{16'h0001, 16'h3F80, 1'b0, 16'h3F80, 4'b0000};
        vecs[11] = '{16'h3F80, 16'hBF7F, 1'b0, 16'h3B80, 4'b0000};
        vecs[12] = '{16'hFF80, 16'h3F80, 1'b0, 16'hFF80, 4'b0000};
        vecs[13] = '{16'h0081, 16'h0080, 1'b1, 16'h0000, 4'b0010};
        vecs[14] = '{16'h7F7F, 16'h7B00, 1'b0, 16'h7F80, 4'b0101};
        vecs[15] = '{16'hBFC0, 16'hBF00, 1'b0, 16'hC000, 4'b0000};
        vecs[16] = '{16'h3F80, 16'h4000, 1'b1, 16'hBF80, 4'b0000};

        bp_a   = '{16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80};
        bp_b   = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080};
        bp_exp = '{16'h4000, 16'h4040, 16'h4080, 16'h40A0};

        nreset = 1'b0;
        bf_in_valid = 1'b0; bf_a = '0; bf_b = '0; bf_op = 1'b0; bf_out_ready = 1'b1;
        dp_in_valid = 1'b0; dp_a = '0; dp_b = '0; dp_op = 1'b0; dp_out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", 64'(bf_out_valid), 64'(0));
        check("rst_result", 64'(bf_result), 64'(0));
        check("rst_flags", 64'(bf_flags), 64'(0));
        nreset = 1'b1;
        @(posedge clock); #1;
        check("rst_in_ready", 64'(bf_in_ready), 64'(1));

        // Directed bf16 vectors
        for (int i = 0; i < NV; i++) begin
            bf_run(vecs[i].a, vecs[i].b, vecs[i].op, r16, f4, lat);
            check($sformatf("v%0d_result", i), 64'(r16), 64'(vecs[i].res));
            check($sformatf("v%0d_flags", i), 64'(f4), 64'(vecs[i].flg));
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(3));
        end
        @(posedge clock); #1;

        // Backpressure: four ops into a stalled pipe, then drain
        bf_out_ready = 1'b0;
        issued = 0;
        bf_a = bp_a[0]; bf_b = bp_b[0]; bf_op = 1'b0; bf_in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            rdy = bf_in_ready;
            @(posedge clock); #1;
            if (bf_in_valid && rdy) begin
                issued++;
                if (issued < 4) begin
                    bf_a = bp_a[issued]; bf_b = bp_b[issued];
                end else begin
                    bf_in_valid = 1'b0;
                end
            end
        end
        check("bp_accepts", 64'(issued), 64'(3));
        check("bp_in_ready", 64'(bf_in_ready), 64'(0));
        check("bp_out_valid", 64'(bf_out_valid), 64'(1));
        check("bp_held_a", 64'(bf_result), 64'(bp_exp[0]));
        repeat (3) @(posedge clock);
        #1;
        check("bp_held_b", 64'(bf_result), 64'(bp_exp[0]));
        check("bp_held_flags", 64'(bf_flags), 64'(0));

        bf_out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            rdy  = bf_in_ready;
            vld  = bf_out_valid;
            rres = bf_result;
            @(posedge clock); #1;
            if (vld) begin
                check($sformatf("bp_drain%0d", got), 64'(rres), 64'(bp_exp[got]));
                got++;
            end
            if (bf_in_valid && rdy) begin
                issued++;
                if (issued < 4) begin
                    bf_a = bp_a[issued]; bf_b = bp_b[issued];
                end else begin
                    bf_in_valid = 1'b0;
                end
            end
        end
        check("bp_drain_count", 64'(got), 64'(4));
        repeat (4) @(posedge clock);
        #1;
        check("bp_no_dup", 64'(bf_out_valid), 64'(0));

        // Reset with two operations in flight
        bf_a = 16'h4040; bf_b = 16'h4040; bf_op = 1'b0; bf_in_valid = 1'b1;
        @(posedge clock); #1;
        bf_a = 16'h3F80; bf_b = 16'h4000;
        @(posedge clock); #1;
        bf_in_valid = 1'b0;
        nreset = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(bf_out_valid), 64'(0));
        check("mid_rst_result", 64'(bf_result), 64'(0));
        @(posedge clock); #1;
        nreset = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("mid_rst_flushed", 64'(bf_out_valid), 64'(0));
        bf_run(16'h3F80, 16'h3F80, 1'b0, r16, f4, lat);
        check("post_rst_result", 64'(r16), 64'(16'h4000));
        check("post_rst_latency", 64'(lat), 64'(3));
        @(posedge clock); #1;

        // Double precision: one directed value, then a random sweep against real math
        dp_run(64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0, r64, lat);
        check("dp_one_plus_one", r64, 64'h4000000000000000);
        check("dp_latency", 64'(lat), 64'(3));
        for (int i = 0; i < 40; i++) begin
            ra64 = rnd_dbl();
            rb64 = (i % 8 == 0) ? ra64 : rnd_dbl();
            rop  = 1'($urandom_range(0, 1));
            xr = $bitstoreal(ra64);
            yr = $bitstoreal(rb64);
            zr = rop ? (xr - yr) : (xr + yr);
            tmp64 = $realtobits(zr);
            exp64 = tmp64;
            dp_run(ra64, rb64, rop, r64, lat);
            check($sformatf("dp_rand%0d_%h_%h_%0d", i, ra64, rb64, rop), r64, exp64);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
